sram_arbiter: RTL and testbench

- Shares the single asynchronous 8-bit SRAM (cen/oen/wen active-low, bidirectional dq) between two bus masters: m0 (CPU core) and m1 (program loader / debug DMA).
- Sequences every access with the SRAM control timing the CPU already uses.
- Sits between the masters and the sram instance, and is the only driver of the SRAM pins.
- Each master uses a level req / single-cycle ack handshake.

---
 rtl/sram_arbiter_if.sv | 41 ++++
 rtl/sram_arbiter.sv | 160 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Two-master request/ack bus into the SRAM arbiter.
// Build option: SRAM_ARB_LOCK_EN adds the m0_lock input for CPU read-modify-write locking.
interface sram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack;
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;
  logic              busy;
`ifdef SRAM_ARB_LOCK_EN
  logic              m0_lock;
`endif

  modport master (
`ifdef SRAM_ARB_LOCK_EN
    output m0_lock,
`endif
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m0_rdata, m0_ack, m1_rdata, m1_ack, busy
  );

  modport slave (
`ifdef SRAM_ARB_LOCK_EN
    input  m0_lock,
`endif
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m0_rdata, m0_ack, m1_rdata, m1_ack, busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// Arbitrates two masters onto one asynchronous 8-bit SRAM and sequences the
// read (RD) and write (WSETUP/WPULSE/WHOLD) pin timing; sole driver of the SRAM pins.
// Build option: SRAM_ARB_LOCK_EN lets m0 hold the SRAM across transactions via m0_lock.
module sram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  sram_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_cen,
  output logic              sram_oen,
  output logic              sram_wen,
  inout  wire  [DATA_W-1:0] sram_dq
);

  typedef enum logic [2:0] {IDLE, RD, WSETUP, WPULSE, WHOLD, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic              cen_n, oen_n, wen_n;
  logic              den, den_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic              who, who_n;      // 0 = m0 owns the current transaction
  logic              last, last_n;    // last granted master
  logic              lock_q, lock_n;
  logic [DATA_W-1:0] rdata0, rdata0_n, rdata1, rdata1_n;
  logic              ack0, ack0_n, ack1, ack1_n;
  logic              grant, pick;

  assign sram_dq      = den ? wdata_q : 'z;
  assign bus.busy     = (state != IDLE);
  assign bus.m0_ack   = ack0;
  assign bus.m1_ack   = ack1;
  assign bus.m0_rdata = rdata0;
  assign bus.m1_rdata = rdata1;

  // State and all registered pin/handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sram_addr <= '0;
      sram_cen  <= 1'b1;
      sram_oen  <= 1'b1;
      sram_wen  <= 1'b1;
      den       <= 1'b0;
      wdata_q   <= '0;
      who       <= 1'b0;
      last      <= 1'b1;
      lock_q    <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
    end else begin
      state     <= state_n;
      sram_addr <= addr_n;
      sram_cen  <= cen_n;
      sram_oen  <= oen_n;
      sram_wen  <= wen_n;
      den       <= den_n;
      wdata_q   <= wdata_n;
      who       <= who_n;
      last      <= last_n;
      lock_q    <= lock_n;
      rdata0    <= rdata0_n;
      rdata1    <= rdata1_n;
      ack0      <= ack0_n;
      ack1      <= ack1_n;
    end
  end

  // Arbitration, next state and next values of the registered outputs.
  always_comb begin
    state_n  = state;
    addr_n   = sram_addr;
    cen_n    = sram_cen;
    oen_n    = sram_oen;
    wen_n    = sram_wen;
    den_n    = den;
    wdata_n  = wdata_q;
    who_n    = who;
    last_n   = last;
    lock_n   = lock_q;
    rdata0_n = rdata0;
    rdata1_n = rdata1;
    ack0_n   = 1'b0;
    ack1_n   = 1'b0;
    grant    = 1'b0;
    pick     = 1'b0;

    unique case (state)
      IDLE: begin
        if (lock_q) begin
          grant = bus.m0_req;
          pick  = 1'b0;
        end else if (bus.m0_req && bus.m1_req) begin
          grant = 1'b1;
          pick  = RR_EN ? ~last : 1'b0;
        end else if (bus.m0_req) begin
          grant = 1'b1;
          pick  = 1'b0;
        end else if (bus.m1_req) begin
          grant = 1'b1;
          pick  = 1'b1;
        end
        if (grant) begin
          who_n   = pick;
          last_n  = pick;
          addr_n  = pick ? bus.m1_addr  : bus.m0_addr;
          wdata_n = pick ? bus.m1_wdata : bus.m0_wdata;
          if (pick ? bus.m1_we : bus.m0_we) begin
            den_n   = 1'b1;
            cen_n   = 1'b1;
            oen_n   = 1'b1;
            wen_n   = 1'b1;
            state_n = WSETUP;
          end else begin
            cen_n   = 1'b0;
            oen_n   = 1'b0;
            state_n = RD;
          end
        end
      end
      RD: begin
        if (who) rdata1_n = sram_dq;
        else     rdata0_n = sram_dq;
        cen_n   = 1'b1;
        oen_n   = 1'b1;
        state_n = DONE;
      end
      WSETUP: begin
        cen_n   = 1'b0;
        wen_n   = 1'b0;
        state_n = WPULSE;
      end
      WPULSE: begin
        cen_n   = 1'b1;
        wen_n   = 1'b1;
        state_n = WHOLD;
      end
      WHOLD: begin
        den_n   = 1'b0;
        state_n = DONE;
      end
      DONE: begin
        if (who) ack1_n = 1'b1;
        else     ack0_n = 1'b1;
`ifdef SRAM_ARB_LOCK_EN
        if (!who) lock_n = bus.m0_lock;
`endif
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, and a fixed-priority
// instance for the starvation case. SRAM_ARB_LOCK_EN adds the lock scenario.
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  logic [AW-1:0] sram_addr;
  logic          sram_cen, sram_oen, sram_wen;
  wire  [DW-1:0] sram_dq;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus), .sram_addr(sram_addr),
    .sram_cen(sram_cen), .sram_oen(sram_oen), .sram_wen(sram_wen), .sram_dq(sram_dq));

  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_fp ();
  logic [AW-1:0] fp_addr;
  logic          fp_cen, fp_oen, fp_wen;
  wire  [DW-1:0] fp_dq;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .reset(reset), .bus(bus_fp), .sram_addr(fp_addr),
    .sram_cen(fp_cen), .sram_oen(fp_oen), .sram_wen(fp_wen), .sram_dq(fp_dq));

  // Fixed-priority instance sees a ROM returning the inverted address.
  assign fp_dq = (!fp_cen && !fp_oen) ? ~fp_addr : 'z;

  function automatic logic [7:0] pat(input int unsigned i);
    logic [7:0] v;
    v = 8'(i) ^ 8'hA5;
    if (i == 16) v = 8'h5A;
    return v;
  endfunction

  // Asynchronous SRAM model: drives on cen/oen low, stores mid write pulse.
  logic [7:0] mem [256];
  bit         mem_ready;
  assign sram_dq = (!sram_cen && !sram_oen) ? mem[sram_addr] : 'z;
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      mem_ready <= 1'b1;
    end else if (!sram_cen && !sram_wen) begin
      mem[sram_addr] <= sram_dq;
    end
  end

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one transaction at a time, counted in cycles since grant.
  bit          started, active, m_who, m_wr, m_last, m_lock;
  int unsigned m_t;
  logic [7:0]  m_addr, m_wd, e_addr;
  logic [7:0]  ref_mem [256];
  logic [7:0]  e_rd [2];
  logic        e_ack [2];

  always @(posedge clk) begin
    bit g, w;
    cyc++;
    if (reset) begin
      if (!started) for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
      started = 1'b1;
      active  = 1'b0;
      m_last  = 1'b1;
      m_lock  = 1'b0;
      e_ack[0] = 1'b0; e_ack[1] = 1'b0;
      e_rd[0]  = 8'h00; e_rd[1] = 8'h00;
      e_addr   = 8'h00;
    end else if (started) begin
      e_ack[0] = 1'b0; e_ack[1] = 1'b0;
      if (active) begin
        m_t++;
        if (!m_wr && m_t == 2) e_rd[m_who] = ref_mem[m_addr];
        if (m_t == (m_wr ? 5 : 3)) begin
          active = 1'b0;
          e_ack[m_who] = 1'b1;
          if (m_wr) ref_mem[m_addr] = m_wd;
`ifdef SRAM_ARB_LOCK_EN
          if (!m_who) m_lock = bus.m0_lock;
`endif
        end
      end else begin
        g = 1'b0; w = 1'b0;
        if (m_lock) g = bus.m0_req;
        else if (bus.m0_req && bus.m1_req) begin g = 1'b1; w = !m_last; end
        else if (bus.m0_req) g = 1'b1;
        else if (bus.m1_req) begin g = 1'b1; w = 1'b1; end
        if (g) begin
          active = 1'b1;
          m_t    = 1;
          m_who  = w;
          m_last = w;
          m_wr   = w ? bus.m1_we    : bus.m0_we;
          m_addr = w ? bus.m1_addr  : bus.m0_addr;
          m_wd   = w ? bus.m1_wdata : bus.m0_wdata;
          e_addr = m_addr;
        end
      end
    end
  end

  int unsigned cen_lo = 0, wen_lo = 0;

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    bit rd1, w2, den;
    if (started) begin
      rd1 = active && !m_wr && m_t == 1;
      w2  = active && m_wr && m_t == 2;
      den = active && m_wr && m_t >= 1 && m_t <= 3;
      chk("m0_ack",    bus.m0_ack,   e_ack[0]);
      chk("m1_ack",    bus.m1_ack,   e_ack[1]);
      chk("m0_rdata",  bus.m0_rdata, e_rd[0]);
      chk("m1_rdata",  bus.m1_rdata, e_rd[1]);
      chk("busy",      bus.busy,     active);
      chk("sram_addr", sram_addr,    e_addr);
      chk("sram_cen",  sram_cen,     !(rd1 || w2));
      chk("sram_oen",  sram_oen,     !rd1);
      chk("sram_wen",  sram_wen,     !w2);
      if (den) chk("dq_drive", sram_dq, m_wd);
      if (!sram_cen) cen_lo++;
      if (!sram_wen) wen_lo++;
    end
  end

  int unsigned ack_cyc [2];
  int unsigned ack_cnt [2];
  int          order [$];

  // Wait for `want` acks; drop each master's req on its ack unless `keep`.
  task automatic serve(input int unsigned want, input int unsigned budget, input bit keep);
    int unsigned got, b;
    got = 0; b = 0;
    while (got < want && b < budget) begin
      @(negedge clk); b++;
      if (bus.m0_ack) begin
        if (!keep) bus.m0_req = 1'b0;
        ack_cyc[0] = cyc; ack_cnt[0]++; order.push_back(0); got++;
      end
      if (bus.m1_ack) begin
        if (!keep) bus.m1_req = 1'b0;
        ack_cyc[1] = cyc; ack_cnt[1]++; order.push_back(1); got++;
      end
    end
    if (keep) begin bus.m0_req = 1'b0; bus.m1_req = 1'b0; end
    if (got < want) chk("serve_timeout", got, want);
  endtask

  task automatic req0(input bit we, input logic [7:0] a, input logic [7:0] d);
    bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_req = 1'b1;
  endtask

  task automatic req1(input bit we, input logic [7:0] a, input logic [7:0] d);
    bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_req = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0, c0, w0, n0, n1;
    logic [3:0]  ord;
    reset = 1'b1;
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus_fp.m0_req = 1'b0; bus_fp.m0_we = 1'b0; bus_fp.m0_addr = '0; bus_fp.m0_wdata = '0;
    bus_fp.m1_req = 1'b0; bus_fp.m1_we = 1'b0; bus_fp.m1_addr = '0; bus_fp.m1_wdata = '0;
`ifdef SRAM_ARB_LOCK_EN
    bus.m0_lock = 1'b0; bus_fp.m0_lock = 1'b0;
`endif
    ack_cnt[0] = 0; ack_cnt[1] = 0; ack_cyc[0] = 0; ack_cyc[1] = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   bus.busy,     0);
    chk("rst_cen",    sram_cen,     1);
    chk("rst_oen",    sram_oen,     1);
    chk("rst_wen",    sram_wen,     1);
    chk("rst_addr",   sram_addr,    0);
    chk("rst_rdata0", bus.m0_rdata, 0);
    reset = 1'b0;
    @(negedge clk);

    // m0 read of 0x10
    c0 = cen_lo; t0 = cyc;
    req0(1'b0, 8'h10, 8'h00);
    serve(1, 20, 1'b0);
    chk("rd_latency", ack_cyc[0] - t0, 3);
    chk("rd_data",    bus.m0_rdata, 8'h5A);
    chk("rd_cen_cycles", cen_lo - c0, 1);

    // m1 write 0x3C to 0x80, then read back by m0
    c0 = cen_lo; w0 = wen_lo; t0 = cyc;
    req1(1'b1, 8'h80, 8'h3C);
    serve(1, 20, 1'b0);
    chk("wr_latency",    ack_cyc[1] - t0, 5);
    chk("wr_cen_cycles", cen_lo - c0, 1);
    chk("wr_wen_cycles", wen_lo - w0, 1);
    chk("wr_mem",        mem[8'h80], 8'h3C);
    req0(1'b0, 8'h80, 8'h00);
    serve(1, 20, 1'b0);
    chk("rdback_0x80",   bus.m0_rdata, 8'h3C);
    chk("m1_rdata_kept", bus.m1_rdata, 8'h00);

    // Continuous reads from both: last grant was m0, so m1 leads
    order.delete();
    req0(1'b0, 8'h01, 8'h00);
    req1(1'b0, 8'h02, 8'h00);
    serve(4, 40, 1'b1);
    chk("rr_count", order.size(), 4);
    if (order.size() >= 4) begin
      ord = {order[0][0], order[1][0], order[2][0], order[3][0]};
      chk("rr_order", ord, 4'b1010);
    end
    chk("rr_m0_rdata", bus.m0_rdata, 8'hA4);
    chk("rr_m1_rdata", bus.m1_rdata, 8'hA7);
    repeat (2) @(negedge clk);

    // m1 raises req during an m0 write
    n0 = ack_cnt[0]; n1 = ack_cnt[1];
    req0(1'b1, 8'h40, 8'h77);
    repeat (2) @(negedge clk);
    req1(1'b0, 8'h40, 8'h00);
    serve(2, 40, 1'b0);
    chk("busy_gap",      ack_cyc[1] - ack_cyc[0], 3);
    chk("busy_m1_rdata", bus.m1_rdata, 8'h77);
    chk("busy_m0_acks",  ack_cnt[0] - n0, 1);
    chk("busy_m1_acks",  ack_cnt[1] - n1, 1);
    repeat (2) @(negedge clk);

    // Address boundaries
    req1(1'b1, 8'hFF, 8'hC3);
    serve(1, 20, 1'b0);
    req0(1'b0, 8'hFF, 8'h00);
    serve(1, 20, 1'b0);
    chk("rd_0xff", bus.m0_rdata, 8'hC3);
    req0(1'b0, 8'h00, 8'h00);
    serve(1, 20, 1'b0);
    chk("rd_0x00", bus.m0_rdata, 8'hA5);

    // Reset during WSETUP aborts the write
    req0(1'b1, 8'h90, 8'hEE);
    @(negedge clk);
    chk("wsetup_busy", bus.busy, 1);
    reset = 1'b1; bus.m0_req = 1'b0;
    @(negedge clk);
    chk("abort_busy", bus.busy,   0);
    chk("abort_cen",  sram_cen,   1);
    chk("abort_oen",  sram_oen,   1);
    chk("abort_wen",  sram_wen,   1);
    chk("abort_ack",  bus.m0_ack, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_ack", bus.m0_ack, 0);
    req0(1'b0, 8'h90, 8'h00);
    serve(1, 20, 1'b0);
    chk("abort_mem_kept", bus.m0_rdata, 8'h35);

    // Fixed priority: m1 starves while m0_req stays high
    n0 = 0; n1 = 0;
    bus_fp.m0_addr = 8'h33; bus_fp.m1_addr = 8'h44;
    bus_fp.m0_req = 1'b1; bus_fp.m1_req = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (bus_fp.m0_ack) n0++;
      if (bus_fp.m1_ack) n1++;
    end
    bus_fp.m0_req = 1'b0; bus_fp.m1_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("fp_m1_starved", n1, 0);
    chk("fp_m0_served",  n0 >= 8, 1);
    chk("fp_m0_rdata",   bus_fp.m0_rdata, 8'hCC);
    chk("fp_m1_rdata",   bus_fp.m1_rdata, 8'h00);

`ifdef SRAM_ARB_LOCK_EN
    // Locked m0 read keeps m1 out until an unlocked m0 write completes
    bus.m0_lock = 1'b1;
    req0(1'b0, 8'h20, 8'h00);
    serve(1, 20, 1'b0);
    bus.m0_lock = 1'b0;
    n1 = ack_cnt[1];
    req1(1'b0, 8'h21, 8'h00);
    repeat (8) begin
      @(negedge clk);
      if (bus.m1_ack) n1 = n1 + 100;
    end
    chk("lock_m1_blocked", n1 - ack_cnt[1], 0);
    chk("lock_idle", bus.busy, 0);
    req0(1'b1, 8'h22, 8'h99);
    serve(2, 40, 1'b0);
    chk("lock_release_gap", ack_cyc[1] - ack_cyc[0], 3);
    chk("lock_m1_rdata", bus.m1_rdata, pat(8'h21));
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
